// File: rtl/pipe_pkg.sv
// Shared constants and entry layout for the MEM/WB pipeline register.
package pipe_pkg;

   localparam int unsigned CTRL_WREG  = 0;
   localparam int unsigned CTRL_M2REG = 1;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_RN_W   = 5;
   localparam int unsigned DEF_CTRL_W = 2;

   typedef struct packed {
      logic [DEF_CTRL_W-1:0] ctrl;
      logic [DEF_DATA_W-1:0] alu;
      logic [DEF_DATA_W-1:0] mo;
      logic [DEF_RN_W-1:0]   rn;
   } entry_t;

   function automatic int unsigned entry_width(int unsigned ctrl_w, int unsigned data_w,
                                               int unsigned rn_w);
      return ctrl_w + 2 * data_w + rn_w;
   endfunction

endpackage

// File: rtl/pipe_mw_skid_reg_if.sv
// Valid/ready stage bus carrying MEM/WB control, ALU result, memory data and destination.
interface pipe_mw_skid_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RN_W   = DEF_RN_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W
);

   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] alu;
   logic [DATA_W-1:0] mo;
   logic [RN_W-1:0]   rn;

   modport master (output valid, ctrl, alu, mo, rn, input ready);
   modport slave  (input valid, ctrl, alu, mo, rn, output ready);

endinterface

// File: rtl/pipe_skid_slot.sv
// One valid+payload holding register; clear beats load, data survives a clear.
module pipe_skid_slot #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic             valid_d, valid_q;
   logic [Width-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_mw_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer; in_ready is a flop output so
// WB backpressure never forms a combinational path into MEM.
module pipe_mw_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RN_W   = DEF_RN_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   pipe_mw_skid_reg_if.slave   in_if,
   pipe_mw_skid_reg_if.master  out_if,
   output logic [DATA_W-1:0]   out_wdata_o,
   output logic [1:0]          occupancy_o
);

   localparam int unsigned EntryW = entry_width(CTRL_W, DATA_W, RN_W);

   logic [EntryW-1:0] in_entry, main_d, main_entry, skid_entry;
   logic              main_valid, skid_valid;
   logic              accept, main_free;
   logic              main_load, main_clr, skid_load, skid_clr;

   logic [CTRL_W-1:0] main_ctrl, ctrl_gated;
   logic [DATA_W-1:0] main_alu, main_mo;
   logic [RN_W-1:0]   main_rn;

   assign in_entry = {in_if.ctrl, in_if.alu, in_if.mo, in_if.rn};

   // Skid always drains into main before any new input is taken.
   always_comb begin
      accept    = in_if.valid & ~skid_valid;
      main_free = ~main_valid | out_if.ready;
      main_load = ~flush_i & main_free & (skid_valid | accept);
      main_clr  = flush_i | (main_free & ~skid_valid & ~accept);
      main_d    = skid_valid ? skid_entry : in_entry;
      skid_load = ~flush_i & ~main_free & accept;
      skid_clr  = flush_i | main_free;
   end

   pipe_skid_slot #(
      .Width (EntryW)
   ) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (main_load),
      .clr_i   (main_clr),
      .data_i  (main_d),
      .valid_o (main_valid),
      .data_o  (main_entry)
   );

   pipe_skid_slot #(
      .Width (EntryW)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .data_i  (in_entry),
      .valid_o (skid_valid),
      .data_o  (skid_entry)
   );

   assign {main_ctrl, main_alu, main_mo, main_rn} = main_entry;

   // A bubble must never raise wreg or m2reg.
   always_comb begin
      ctrl_gated  = main_valid ? main_ctrl : '0;
      out_wdata_o = ctrl_gated[CTRL_M2REG] ? main_mo : main_alu;
   end

   assign out_if.valid = main_valid;
   assign out_if.ctrl  = ctrl_gated;
   assign out_if.alu   = main_alu;
   assign out_if.mo    = main_mo;
   assign out_if.rn    = main_rn;

   assign in_if.ready  = ~skid_valid;
   assign occupancy_o  = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
